// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT analysis path: default widths, decimation
// phase constants and the signed saturate-narrow helpers.
package dwt_pkg;

   localparam int W_IN_DEF  = 40;
   localparam int W_OUT_DEF = 25;

   localparam bit PHASE_EVEN = 1'b0;
   localparam bit PHASE_ODD  = 1'b1;

   // Largest and smallest value representable in a signed field of width w.
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   function automatic logic sat_clip(input logic signed [63:0] x, input int w);
      return (x > sat_max(w)) || (x < sat_min(w));
   endfunction

   // Callers keep only the low w bits; the clamp guarantees they never wrap.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x, input int w);
      if (x > sat_max(w))
         return sat_max(w);
      else if (x < sat_min(w))
         return sat_min(w);
      else
         return x;
   endfunction

endpackage

// File: rtl/dwt_fifo2.sv
// Two-entry synchronous FIFO whose head entry is held in its own register,
// so the consumer always sees a flop output.
module dwt_fifo2 #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);

   logic [W-1:0] tail;
   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   logic         push_ok;
   logic         pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      cnt_nxt = cnt;
      if (push_ok && !pop_ok)
         cnt_nxt = cnt + 2'd1;
      else if (pop_ok && !push_ok)
         cnt_nxt = cnt - 2'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= 2'd0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (push_ok && !pop_ok) begin
            if (cnt == 2'd0)
               head <= push_data;
            else
               tail <= push_data;
         end else if (pop_ok && !push_ok) begin
            if (cnt == 2'd2)
               head <= tail;
         end else if (push_ok && pop_ok) begin
            // Only reachable with one entry: the new word replaces the head.
            head <= push_data;
         end
         cnt   <= cnt_nxt;
         empty <= (cnt_nxt == 2'd0);
         full  <= (cnt_nxt == 2'd2);
      end
   end

endmodule

// File: rtl/dwt_downsample.sv
// Decimate-by-2 stage of the DWT analysis path: keeps one sample per pair,
// saturates it to the coefficient width and queues it for the consumer.
module dwt_downsample
   import dwt_pkg::*;
#(
   parameter int W_IN  = W_IN_DEF,
   parameter int W_OUT = W_OUT_DEF,
   parameter bit PHASE = PHASE_EVEN
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sof,
   input  logic signed [W_IN-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [W_OUT-1:0] out_data,
   output logic                    out_sat
);

   // Handshake: a word moves on a rising edge where valid & ready are both 1;
   // valid never waits on ready, and in_ready comes only from queue state, so
   // out_ready has no combinational path to in_ready.

   logic             ph;
   logic             idx;
   logic             xfer;
   logic             keep;
   logic             fifo_empty;
   logic             fifo_full;
   logic signed [63:0] in_ext;
   logic [W_OUT:0]   push_word;
   logic [W_OUT:0]   head_word;

   assign in_ready = ~fifo_full;
   assign xfer     = in_valid & in_ready;
   assign idx      = in_sof ? 1'b0 : ph;
   assign keep     = xfer & (idx == PHASE);

   // Phase only moves on an accepted sample; in_sof realigns it to index 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ph <= 1'b0;
      else if (xfer)
         ph <= ~idx;
   end

   assign in_ext    = 64'(in_data);
   assign push_word = {sat_clip(in_ext, W_OUT), W_OUT'(sat_narrow(in_ext, W_OUT))};

   dwt_fifo2 #(
      .W(W_OUT + 1)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (keep),
      .push_data (push_word),
      .pop       (out_valid & out_ready),
      .head      (head_word),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign out_valid = ~fifo_empty;
   assign out_data  = head_word[W_OUT-1:0];
   assign out_sat   = head_word[W_OUT];

endmodule
